// File: rtl/corep_pkg.sv
// Core-wide shared types: branch-predictor payload fields and the ibtb update-queue entry.
package corep;

    localparam int unsigned PC38_W    = 38;
    localparam int unsigned IBTB_GH_W = 8;
    localparam int unsigned ASID_W    = 16;
    localparam int unsigned IBTB_INFO_W = 32;

    typedef logic [PC38_W-1:0]      pc38_t;
    typedef logic [IBTB_GH_W-1:0]   ibtb_gh_t;
    typedef logic [ASID_W-1:0]      asid_t;
    typedef logic [IBTB_INFO_W-1:0] ibtb_info_t;

    localparam int unsigned IBTB_UQ_DEPTH = 8;
    localparam int unsigned IBTB_UQ_IDX_W = $clog2(IBTB_UQ_DEPTH);

    typedef struct packed {
        pc38_t      src_pc38;
        ibtb_gh_t   ibtb_gh;
        asid_t      asid;
        ibtb_info_t tgt_ibtb_info;
    } ibtb_uq_entry_t;

endpackage

// File: rtl/ibtb_update_queue.sv
// Circular buffer of resolved indirect-branch updates draining one per cycle into the ibtb,
// merging a new update into the newest entry when they target the same ibtb slot.
module ibtb_update_queue
    import corep::*;
(
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  pc38_t                    enq_src_pc38,
    input  ibtb_gh_t                 enq_ibtb_gh,
    input  asid_t                    enq_asid,
    input  ibtb_info_t               enq_tgt_ibtb_info,
    input  logic                     clear,
    input  logic                     update_stall,
    output logic                     update_valid,
    output pc38_t                    update_src_pc38,
    output ibtb_gh_t                 update_ibtb_gh,
    output asid_t                    update_asid,
    output ibtb_info_t               update_tgt_ibtb_info,
    output logic [IBTB_UQ_IDX_W:0]   occupancy
);

    localparam int unsigned PTR_W = IBTB_UQ_IDX_W + 1;

    ibtb_uq_entry_t           mem_q [IBTB_UQ_DEPTH];
    logic [PTR_W-1:0]         head_q, tail_q, occ_q;
    logic [PTR_W-1:0]         head_d, tail_d;
    logic [IBTB_UQ_IDX_W-1:0] head_idx, tail_idx, newest_idx;
    logic                     empty, full, deq, key_match, merge, wr_new, wr_merge;
    ibtb_uq_entry_t           head_entry;

    // Pointer/merge control and head presentation
    always_comb begin
        empty      = 1'b0;
        full       = 1'b0;
        deq        = 1'b0;
        key_match  = 1'b0;
        merge      = 1'b0;
        wr_new     = 1'b0;
        wr_merge   = 1'b0;
        head_d     = head_q;
        tail_d     = tail_q;
        head_entry = '0;

        head_idx   = head_q[IBTB_UQ_IDX_W-1:0];
        tail_idx   = tail_q[IBTB_UQ_IDX_W-1:0];
        newest_idx = tail_idx - IBTB_UQ_IDX_W'(1);

        empty = (head_q == tail_q);
        full  = (head_idx == tail_idx) && (head_q[IBTB_UQ_IDX_W] != tail_q[IBTB_UQ_IDX_W]);
        deq   = ~empty & ~update_stall;

        key_match = ({mem_q[newest_idx].src_pc38, mem_q[newest_idx].ibtb_gh, mem_q[newest_idx].asid}
                     == {enq_src_pc38, enq_ibtb_gh, enq_asid});
        // A sole entry leaving this cycle cannot absorb a merge; it becomes a fresh enqueue
        merge = ~empty & key_match & ~(deq & (occ_q == PTR_W'(1)));

        enq_ready = merge | ~full;
        wr_merge  = enq_valid & merge & ~clear;
        wr_new    = enq_valid & enq_ready & ~merge & ~clear;

        if (clear) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + PTR_W'(deq);
            tail_d = tail_q + PTR_W'(wr_new);
        end

        if (!empty) head_entry = mem_q[head_idx];
        update_valid         = ~empty;
        update_src_pc38      = head_entry.src_pc38;
        update_ibtb_gh       = head_entry.ibtb_gh;
        update_asid          = head_entry.asid;
        update_tgt_ibtb_info = head_entry.tgt_ibtb_info;
        occupancy            = occ_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < int'(IBTB_UQ_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= tail_d - head_d;
            if (wr_new) begin
                mem_q[tail_idx] <= '{src_pc38: enq_src_pc38, ibtb_gh: enq_ibtb_gh,
                                     asid: enq_asid, tgt_ibtb_info: enq_tgt_ibtb_info};
            end else if (wr_merge) begin
                mem_q[newest_idx].tgt_ibtb_info <= enq_tgt_ibtb_info;
            end
        end
    end

endmodule

// File: tb/tb_ibtb_update_queue.sv
// Directed + randomized bench for ibtb_update_queue against a queue-level reference model.
module tb_ibtb_update_queue;
    import corep::*;

    logic                   CLK, nRST;
    logic                   enq_valid, enq_ready, clear, update_stall, update_valid;
    pc38_t                  enq_src_pc38, update_src_pc38;
    ibtb_gh_t               enq_ibtb_gh, update_ibtb_gh;
    asid_t                  enq_asid, update_asid;
    ibtb_info_t             enq_tgt_ibtb_info, update_tgt_ibtb_info;
    logic [IBTB_UQ_IDX_W:0] occupancy;

    int n_vec = 0;
    int n_err = 0;
    ibtb_uq_entry_t mq[$];

    ibtb_update_queue dut (
        .CLK(CLK), .nRST(nRST),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_src_pc38(enq_src_pc38), .enq_ibtb_gh(enq_ibtb_gh),
        .enq_asid(enq_asid), .enq_tgt_ibtb_info(enq_tgt_ibtb_info),
        .clear(clear), .update_stall(update_stall),
        .update_valid(update_valid), .update_src_pc38(update_src_pc38),
        .update_ibtb_gh(update_ibtb_gh), .update_asid(update_asid),
        .update_tgt_ibtb_info(update_tgt_ibtb_info), .occupancy(occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ibtb_uq_entry_t mk(input int unsigned pc, input int unsigned gh,
                                          input int unsigned asid, input int unsigned info);
        ibtb_uq_entry_t e;
        e.src_pc38      = PC38_W'(pc);
        e.ibtb_gh       = IBTB_GH_W'(gh);
        e.asid          = ASID_W'(asid);
        e.tgt_ibtb_info = IBTB_INFO_W'(info);
        return e;
    endfunction

    function automatic logic same_key(input ibtb_uq_entry_t a, input ibtb_uq_entry_t b);
        return a.src_pc38 == b.src_pc38 && a.ibtb_gh == b.ibtb_gh && a.asid == b.asid;
    endfunction

    // One clock: drive inputs, check outputs against the model, then advance the model at the edge
    task automatic step(input logic ev, input ibtb_uq_entry_t e, input logic clr, input logic st);
        ibtb_uq_entry_t head, got;
        logic ex_valid, ex_deq, ex_merge, ex_ready, fire;
        enq_valid         = ev;
        enq_src_pc38      = e.src_pc38;
        enq_ibtb_gh       = e.ibtb_gh;
        enq_asid          = e.asid;
        enq_tgt_ibtb_info = e.tgt_ibtb_info;
        clear             = clr;
        update_stall      = st;
        #3;
        ex_valid = (mq.size() != 0);
        head     = ex_valid ? mq[0] : '0;
        ex_deq   = ex_valid && !st;
        ex_merge = ex_valid && same_key(mq[$], e) && !(ex_deq && mq.size() == 1);
        ex_ready = ex_merge || (mq.size() < int'(IBTB_UQ_DEPTH));
        fire     = ev && ex_ready && !clr;
        got      = '{src_pc38: update_src_pc38, ibtb_gh: update_ibtb_gh,
                     asid: update_asid, tgt_ibtb_info: update_tgt_ibtb_info};
        chk("enq_ready", 128'(enq_ready), 128'(ex_ready));
        chk("update_valid", 128'(update_valid), 128'(ex_valid));
        chk("update_data", 128'(got), 128'(head));
        chk("occupancy", 128'(occupancy), 128'(mq.size()));
        @(posedge CLK);
        if (clr) mq.delete();
        else begin
            if (fire && ex_merge) mq[$].tgt_ibtb_info = e.tgt_ibtb_info;
            else if (fire) mq.push_back(e);
            if (ex_deq) void'(mq.pop_front());
        end
        #1;
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, st);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 128'(update_valid), 128'(0));
        chk({tag, "_ready"}, 128'(enq_ready), 128'(1));
        chk({tag, "_occ"}, 128'(occupancy), 128'(0));
        chk({tag, "_data"}, 128'({update_src_pc38, update_ibtb_gh, update_asid, update_tgt_ibtb_info}), 128'(0));
    endtask

    initial begin
        ibtb_uq_entry_t e, x;
        nRST = 1'b0;
        enq_valid = 1'b0; clear = 1'b0; update_stall = 1'b0;
        enq_src_pc38 = '0; enq_ibtb_gh = '0; enq_asid = '0; enq_tgt_ibtb_info = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;

        // single update drains exactly one cycle after enqueue
        step(1'b1, mk(32'h100, 3, 1, 32'hA0A0_0001), 1'b0, 1'b0);
        chk("t1_occ1", 128'(occupancy), 128'(1));
        idle(2, 1'b0);
        chk("t1_occ0", 128'(occupancy), 128'(0));

        // fill under stall, 9th refused, drain in order
        for (int i = 0; i < 8; i++) step(1'b1, mk(32'h200 + 32'(i), i, 2, 32'hB000 + 32'(i)), 1'b0, 1'b1);
        chk("t2_full_occ", 128'(occupancy), 128'(8));
        step(1'b1, mk(32'h2FF, 0, 2, 32'hBAD), 1'b0, 1'b1);
        idle(9, 1'b0);

        // merge with two queued, then merge while full
        step(1'b1, mk(32'h300, 1, 3, 32'hC1), 1'b0, 1'b1);
        step(1'b1, mk(32'h304, 1, 3, 32'hC2), 1'b0, 1'b1);
        step(1'b1, mk(32'h304, 1, 3, 32'hC3), 1'b0, 1'b1);
        chk("t3_merge_occ", 128'(occupancy), 128'(2));
        idle(3, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, mk(32'h310 + 32'(i), 0, 3, 32'hD0 + 32'(i)), 1'b0, 1'b1);
        step(1'b1, mk(32'h317, 0, 3, 32'hDDDD), 1'b0, 1'b1);
        chk("t3_full_merge_occ", 128'(occupancy), 128'(8));
        idle(9, 1'b0);

        // sole head dequeuing does not absorb a same-key enqueue
        x = mk(32'h400, 2, 4, 32'hE1);
        step(1'b1, x, 1'b0, 1'b0);
        x.tgt_ibtb_info = 32'hE2;
        step(1'b1, x, 1'b0, 1'b0);
        chk("t4_no_merge_occ", 128'(occupancy), 128'(1));
        idle(2, 1'b0);

        // clear beats a same-cycle enqueue
        for (int i = 0; i < 5; i++) step(1'b1, mk(32'h500 + 32'(i), 0, 5, 32'hF0 + 32'(i)), 1'b0, 1'b1);
        step(1'b1, mk(32'h5FF, 0, 5, 32'hFF), 1'b1, 1'b0);
        chk("t5_clear_occ", 128'(occupancy), 128'(0));
        chk("t5_clear_valid", 128'(update_valid), 128'(0));
        idle(2, 1'b0);

        // full + dequeue: distinct offer refused, accepted next cycle
        for (int i = 0; i < 8; i++) step(1'b1, mk(32'h600 + 32'(i), 0, 6, 32'h60 + 32'(i)), 1'b0, 1'b1);
        e = mk(32'h6AA, 0, 6, 32'h6A);
        step(1'b1, e, 1'b0, 1'b0);
        step(1'b1, e, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
        idle(10, 1'b0);

        // randomized traffic with a narrow key space so merges are frequent
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                nRST = 1'b0;
                #1;
                check_reset_outputs("async_reset");
                mq.delete();
                @(negedge CLK) nRST = 1'b1;
                @(posedge CLK); #1;
            end
            e = mk(32'h700 + 32'h4 * $urandom_range(0, 2), $urandom_range(0, 1), 7, $urandom);
            step(1'($urandom_range(0, 3) != 0), e, 1'($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 2) == 0));
        end
        idle(10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
